run_controller: RTL and testbench
=================================

# run_controller

Host-facing run sequencer for the accumulator core. It arbitrates the core's data-memory write port between the host preload path and the core. It holds the core in reset while idle and releases it on a host `req`. It then counts execution cycles until the core raises `done` or a timeout expires, and reports completion with a four-phase `req`/`ack` handshake.

## Interface
Parameters:
- `CYCLE_WIDTH`, 16, width of the execution cycle counter.
- `RESET_CYCLES`, 2, number of cycles `core_reset` stays high after a run is accepted (≥1).
- `TIMEOUT_CYCLES`, 4096, run limit in counted cycles (1 ≤ value ≤ 2^CYCLE_WIDTH−1).
- `ADDR_WIDTH`, 8, data-memory address width (256-entry memory).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  1  host run request (four-phase handshake).
- `ack`  out  1  run finished; results valid.
- `busy`  out  1  core is in reset-hold or running.
- `timed_out`  out  1  last run ended by timeout.
- `cycle_count`  out  CYCLE_WIDTH  cycles counted in the last or current run.
- `core_reset`  out  1  active-high reset to core PC/control.
- `core_done`  in  1  core `done` output.
- `host_we`  in  1  host data-memory write strobe.
- `host_addr`  in  ADDR_WIDTH  host write address.
- `host_wdata`  in  8  host write data.
- `host_grant`  out  1  host owns the memory write port.
- `dm_we`  out  1  arbitrated write strobe to the data memory host port.
- `dm_addr`  out  ADDR_WIDTH  arbitrated address.
- `dm_wdata`  out  8  arbitrated write data.

## Operation
- FSM states: IDLE, HOLD, RUN, FINISH. Encoding is free.
- IDLE:
  - `core_reset`=1, `host_grant`=1.
  - `req`=1 → HOLD. On this transition, clear `cycle_count` and `timed_out` and load the hold counter with `RESET_CYCLES`.
- HOLD:
  - `core_reset`=1, `busy`=1.
  - The hold counter decrements each cycle; after `RESET_CYCLES` cycles in HOLD → RUN.
  - `core_done` is ignored in HOLD.
- RUN:
  - `core_reset`=0, `busy`=1.
  - Each edge with `core_done`=1 → FINISH; count unchanged.
  - Otherwise `cycle_count` increments. If the incremented value equals `TIMEOUT_CYCLES` → FINISH with `timed_out`=1.
- FINISH:
  - `ack`=1, `core_reset`=1 (core frozen), `host_grant`=1.
  - `cycle_count` and `timed_out` are held.
  - `req`=0 → IDLE.
- Arbitration:
  - When `host_grant`=1: `dm_we`=`host_we`, `dm_addr`=`host_addr`, `dm_wdata`=`host_wdata`.
  - When `host_grant`=0: `dm_we`=0 and host writes are dropped, not queued. `dm_addr`/`dm_wdata` still pass through.
- `req` changes during HOLD/RUN are ignored; a run cannot be aborted except by `reset`.
- `req` still high on the FINISH→IDLE edge is impossible by construction. A `req` re-raised in IDLE starts a new run.

## Timing
- Reset (`reset`=0 at an edge), from any state including mid-run:
  - State becomes IDLE.
  - `cycle_count`=0, `timed_out`=0, hold counter=0.
  - Outputs after reset: `core_reset`=1, `host_grant`=1, `ack`=0, `busy`=0, `dm_we`=`host_we`.
- Outputs `ack`, `busy`, `core_reset`, `host_grant` are decoded from the state register only (Moore). The `dm_*` outputs are combinational from `host_*` and the state.
- Handshake timeline:
  - `req` sampled high at edge k → HOLD from k.
  - RUN from edge k+`RESET_CYCLES`.
  - `core_done` first sampled high at edge k+`RESET_CYCLES`+n → FINISH with `cycle_count`=n (n=0 if `done` is present at the first RUN edge).
  - `ack` rises after that edge. `req` sampled low in FINISH → `ack` falls after the next edge.
- Timeout: `cycle_count`=`TIMEOUT_CYCLES` at edge k+`RESET_CYCLES`+`TIMEOUT_CYCLES`, which enters FINISH.
- `core_done`=1 on the same edge the count would reach the limit: `done` wins, no increment, `timed_out`=0.
- The counter never wraps, because the limit is below 2^CYCLE_WIDTH.

## Test plan
- Reset: hold `reset`=0 for 1 cycle from RUN → IDLE next edge; `core_reset`=1, `busy`=0, `ack`=0, `cycle_count`=0, `host_grant`=1.
- Preload arbitration:
  - In IDLE, `host_we`=1, `host_addr`=8'h10, `host_wdata`=8'hA5 → same cycle `dm_we`=1, `dm_addr`=8'h10, `dm_wdata`=8'hA5.
  - Same stimulus during RUN → `dm_we`=0.
- Normal run (`RESET_CYCLES`=2):
  - `req`=1; `core_reset` stays high for exactly 2 cycles; `core_done` at the 38th RUN edge → `ack`=1, `cycle_count`=37, `timed_out`=0.
  - `req`=0 → `ack`=0 after one edge.
- Timeout (`TIMEOUT_CYCLES`=100): `core_done` held 0 → FINISH with `cycle_count`=100, `timed_out`=1; the next run clears `timed_out` on accept.
- Boundaries:
  - `core_done`=1 throughout HOLD, then low for 5 RUN edges, then high → `cycle_count`=5.
  - `done` coinciding with count 99→100 (`TIMEOUT_CYCLES`=100) → `cycle_count`=99, `timed_out`=0.
- Back-to-back runs: re-raise `req` one cycle after `ack` falls → new HOLD, `cycle_count` cleared to 0, second result independent of the first.

Source files
------------

// File: rtl/run_controller.sv
// Run sequencer for the accumulator core: holds the core in reset while idle, times a run
// after a host request, and arbitrates the data-memory write port between host and core.
module run_controller #(
  parameter int unsigned CYCLE_WIDTH    = 16,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned ADDR_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  output logic                   ack,
  output logic                   busy,
  output logic                   timed_out,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic                   core_reset,
  input  logic                   core_done,
  input  logic                   host_we,
  input  logic [ADDR_WIDTH-1:0]  host_addr,
  input  logic [7:0]             host_wdata,
  output logic                   host_grant,
  output logic                   dm_we,
  output logic [ADDR_WIDTH-1:0]  dm_addr,
  output logic [7:0]             dm_wdata
);

  localparam int unsigned HoldWidth = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam logic [HoldWidth-1:0]   HoldLoad   = HoldWidth'(RESET_CYCLES);
  localparam logic [CYCLE_WIDTH-1:0] TimeoutVal = CYCLE_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRun,
    StFinish
  } state_e;

  state_e                 state_q, state_d;
  logic [HoldWidth-1:0]   hold_q, hold_d;
  logic [CYCLE_WIDTH-1:0] count_q, count_d;
  logic                   timed_out_q, timed_out_d;
  logic [CYCLE_WIDTH-1:0] count_inc;

  assign count_inc = count_q + CYCLE_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    count_d     = count_q;
    timed_out_d = timed_out_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d     = StHold;
          hold_d      = HoldLoad;
          count_d     = '0;
          timed_out_d = 1'b0;
        end
      end
      StHold: begin
        // core_done is deliberately ignored while the core is still in reset
        hold_d = (hold_q == '0) ? '0 : hold_q - HoldWidth'(1);
        if (hold_q <= HoldWidth'(1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // done takes priority over the increment that would hit the limit
        if (core_done) begin
          state_d = StFinish;
        end else begin
          count_d = count_inc;
          if (count_inc == TimeoutVal) begin
            state_d     = StFinish;
            timed_out_d = 1'b1;
          end
        end
      end
      StFinish: begin
        if (!req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      count_q     <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      count_q     <= count_d;
      timed_out_q <= timed_out_d;
    end
  end

  always_comb begin
    ack        = (state_q == StFinish);
    busy       = (state_q == StHold) || (state_q == StRun);
    core_reset = (state_q != StRun);
    host_grant = (state_q == StIdle) || (state_q == StFinish);
  end

  assign timed_out   = timed_out_q;
  assign cycle_count = count_q;

  // Host writes outside the grant window are dropped; address/data pass through regardless
  assign dm_we    = host_grant & host_we;
  assign dm_addr  = host_addr;
  assign dm_wdata = host_wdata;

endmodule

// File: tb/tb_run_controller.sv
// Directed self-checking bench for run_controller (RESET_CYCLES=2, TIMEOUT_CYCLES=100).
module tb_run_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        ack;
  logic        busy;
  logic        timed_out;
  logic [15:0] cycle_count;
  logic        core_reset;
  logic        core_done;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        host_grant;
  logic        dm_we;
  logic [7:0]  dm_addr;
  logic [7:0]  dm_wdata;

  int checks = 0;
  int errors = 0;

  run_controller #(
    .CYCLE_WIDTH   (16),
    .RESET_CYCLES  (2),
    .TIMEOUT_CYCLES(100),
    .ADDR_WIDTH    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ack        (ack),
    .busy       (busy),
    .timed_out  (timed_out),
    .cycle_count(cycle_count),
    .core_reset (core_reset),
    .core_done  (core_done),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_grant (host_grant),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Accept a run and advance into RUN (no RUN edges taken yet)
  task automatic accept();
    req = 1'b1;
    steps(3);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if ({core_reset, host_grant, ack, busy, timed_out} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 11000",
               {core_reset, host_grant, ack, busy, timed_out});
    end
    checks++;
    if (cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", cycle_count);
    end
  endtask

  task automatic test_arbitration();
    host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hA5;
    #1;
    checks++;
    if ({dm_we, dm_addr, dm_wdata} !== {1'b1, 8'h10, 8'hA5}) begin
      errors++;
      $display("FAIL arb_idle: got we=%b addr=%h data=%h expected we=1 addr=10 data=a5",
               dm_we, dm_addr, dm_wdata);
    end
    accept();
    checks++;
    if ({dm_we, dm_addr, dm_wdata, host_grant} !== {1'b0, 8'h10, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL arb_run: got we=%b addr=%h data=%h grant=%b expected we=0 addr=10 data=a5 grant=0",
               dm_we, dm_addr, dm_wdata, host_grant);
    end
    host_we = 1'b0;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    req = 1'b0;
    step();
  endtask

  task automatic test_normal_run();
    req = 1'b1;
    step();
    checks++;
    if ({core_reset, busy} !== 2'b11) begin
      errors++;
      $display("FAIL hold_cycle1: got core_reset/busy=%b expected 11", {core_reset, busy});
    end
    step();
    checks++;
    if ({core_reset, busy} !== 2'b11) begin
      errors++;
      $display("FAIL hold_cycle2: got core_reset/busy=%b expected 11", {core_reset, busy});
    end
    step();
    checks++;
    if ({core_reset, busy, cycle_count} !== {2'b01, 16'd0}) begin
      errors++;
      $display("FAIL run_entry: got core_reset/busy=%b count=%0d expected 01 count=0",
               {core_reset, busy}, cycle_count);
    end
    steps(37);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if ({ack, busy, core_reset, host_grant, timed_out} !== 5'b10110 || cycle_count !== 16'd37)
    begin
      errors++;
      $display("FAIL normal_finish: got flags=%b count=%0d expected flags=10110 count=37",
               {ack, busy, core_reset, host_grant, timed_out}, cycle_count);
    end
    req = 1'b0;
    step();
    checks++;
    if (ack !== 1'b0 || cycle_count !== 16'd37) begin
      errors++;
      $display("FAIL ack_fall: got ack=%b count=%0d expected ack=0 count=37", ack, cycle_count);
    end
  endtask

  task automatic test_timeout();
    accept();
    steps(99);
    checks++;
    if (ack !== 1'b0 || cycle_count !== 16'd99) begin
      errors++;
      $display("FAIL timeout_pre: got ack=%b count=%0d expected ack=0 count=99", ack, cycle_count);
    end
    step();
    checks++;
    if ({ack, timed_out} !== 2'b11 || cycle_count !== 16'd100) begin
      errors++;
      $display("FAIL timeout_hit: got ack/to=%b count=%0d expected 11 count=100",
               {ack, timed_out}, cycle_count);
    end
    req = 1'b0;
    step();
    req = 1'b1;
    step();
    checks++;
    if ({timed_out, busy} !== 2'b01 || cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL timeout_clear: got to/busy=%b count=%0d expected 01 count=0",
               {timed_out, busy}, cycle_count);
    end
    steps(2);
    // done at the very first RUN edge gives a zero count
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if ({ack, timed_out} !== 2'b10 || cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL done_first_edge: got ack/to=%b count=%0d expected 10 count=0",
               {ack, timed_out}, cycle_count);
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_done_in_hold();
    core_done = 1'b1;
    accept();
    core_done = 1'b0;
    steps(5);
    checks++;
    if ({busy, ack} !== 2'b10 || cycle_count !== 16'd5) begin
      errors++;
      $display("FAIL done_hold_mid: got busy/ack=%b count=%0d expected 10 count=5",
               {busy, ack}, cycle_count);
    end
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if (ack !== 1'b1 || cycle_count !== 16'd5) begin
      errors++;
      $display("FAIL done_hold_end: got ack=%b count=%0d expected ack=1 count=5", ack, cycle_count);
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_done_at_limit();
    accept();
    steps(99);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if ({ack, timed_out} !== 2'b10 || cycle_count !== 16'd99) begin
      errors++;
      $display("FAIL done_at_limit: got ack/to=%b count=%0d expected 10 count=99",
               {ack, timed_out}, cycle_count);
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    accept();
    steps(10);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if (cycle_count !== 16'd10) begin
      errors++;
      $display("FAIL b2b_first: got count=%0d expected 10", cycle_count);
    end
    req = 1'b0;
    step();
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack_fall: got ack=%b expected 0", ack);
    end
    req = 1'b1;
    step();
    checks++;
    if ({busy, core_reset} !== 2'b11 || cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL b2b_accept: got busy/core_reset=%b count=%0d expected 11 count=0",
               {busy, core_reset}, cycle_count);
    end
    steps(2);
    steps(3);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if ({ack, timed_out} !== 2'b10 || cycle_count !== 16'd3) begin
      errors++;
      $display("FAIL b2b_second: got ack/to=%b count=%0d expected 10 count=3",
               {ack, timed_out}, cycle_count);
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_run();
    accept();
    steps(10);
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if ({core_reset, busy, ack, host_grant, timed_out} !== 5'b10010 || cycle_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got flags=%b count=%0d expected flags=10010 count=0",
               {core_reset, busy, ack, host_grant, timed_out}, cycle_count);
    end
    host_we = 1'b1;
    #1;
    checks++;
    if (dm_we !== 1'b1) begin
      errors++;
      $display("FAIL reset_dm_we: got %b expected 1", dm_we);
    end
    host_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; core_done = 1'b0;
    host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    #1;
    test_reset();
    test_arbitration();
    test_normal_run();
    test_timeout();
    test_done_in_hold();
    test_done_at_limit();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
